// File: rtl/wb_timer.sv
// wb_timer: N-channel down-counter timer with a shared prescaler behind a Wishbone slave.
// Ack is registered one cycle after each request and is never stalled; accesses are strictly one at a time.
module wb_timer #(
  parameter int N_TIMERS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [3:0]          i_wb_sel,
  input  logic [31:0]         i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  output logic [31:0]         o_wb_dat,
  output logic                o_wb_ack,
  output logic [N_TIMERS-1:0] o_irq
);

  typedef struct packed {
    logic ie;
    logic reload;
    logic en;
  } ctrl_t;

  logic                w_req;
  logic                w_wr;
  logic [2:0]          w_ch;
  logic [1:0]          w_reg;
  logic                w_ch_space;
  logic                w_presc_hit;
  logic                w_tick;
  logic [31:0]         w_presc_m;
  logic [31:0]         w_rdat;
  logic                w_unused;

  logic                r_ack;
  logic [31:0]         r_dat;
  logic [15:0]         r_presc;
  logic [15:0]         r_pcnt;

  ctrl_t               w_ctrl  [N_TIMERS];
  logic [CNT_W-1:0]    w_load  [N_TIMERS];
  logic [CNT_W-1:0]    w_count [N_TIMERS];
  logic [N_TIMERS-1:0] w_pend;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = new_v[8*b +: 8];
    end
    return m;
  endfunction

  assign w_req       = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_wr        = w_req & i_wb_we;
  assign w_ch        = i_wb_adr[6:4];
  assign w_reg       = i_wb_adr[3:2];
  assign w_ch_space  = ~i_wb_adr[7] & ({1'b0, w_ch} < 4'(N_TIMERS));
  assign w_presc_hit = (i_wb_adr[7:2] == 6'h20);
  assign w_presc_m   = f_merge({16'h0, r_presc}, i_wb_dat, i_wb_sel);
  assign w_unused    = ^{i_wb_adr[31:8], i_wb_adr[1:0], w_presc_m[31:16]};

  // Tick fires when the counter reaches PRESC, so PRESC=0 ticks every cycle.
  assign w_tick = (r_pcnt == r_presc);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_presc <= '0;
      r_pcnt  <= '0;
    end else if (w_wr && w_presc_hit) begin
      r_presc <= w_presc_m[15:0];
      r_pcnt  <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

  for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_load;
    logic [CNT_W-1:0] r_count;
    logic             r_pend;
    logic             r_irq;
    logic             w_sel;
    logic             w_ctrl_wr;
    logic             w_load_wr;
    logic             w_clr;
    logic             w_expire;
    logic [31:0]      w_load_m;

    assign w_sel     = w_wr & w_ch_space & (w_ch == 3'(k));
    assign w_ctrl_wr = w_sel & (w_reg == 2'd0) & i_wb_sel[0];
    assign w_load_wr = w_sel & (w_reg == 2'd1);
    assign w_clr     = w_sel & (w_reg == 2'd3) & i_wb_sel[0] & i_wb_dat[0];
    assign w_expire  = w_tick & r_ctrl.en & (r_count == '0);
    assign w_load_m  = f_merge(32'(r_load), i_wb_dat, i_wb_sel);

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        r_ctrl  <= '0;
        r_load  <= '0;
        r_count <= '0;
        r_pend  <= 1'b0;
        r_irq   <= 1'b0;
      end else begin
        if (w_tick && r_ctrl.en) begin
          if (r_count != '0)    r_count   <= r_count - CNT_W'(1);
          else if (r_ctrl.reload) r_count <= r_load;
          else                  r_ctrl.en <= 1'b0;
        end
        // A CTRL write overrides the expiry's EN update; only a 0->1 edge reloads.
        if (w_ctrl_wr) begin
          r_ctrl <= ctrl_t'(i_wb_dat[2:0]);
          if (!r_ctrl.en && i_wb_dat[0]) r_count <= r_load;
        end
        if (w_load_wr) r_load <= w_load_m[CNT_W-1:0];
        if (w_expire)   r_pend <= 1'b1;
        else if (w_clr) r_pend <= 1'b0;
        r_irq <= r_pend & r_ctrl.ie;
      end
    end

    assign w_ctrl[k]  = r_ctrl;
    assign w_load[k]  = r_load;
    assign w_count[k] = r_count;
    assign w_pend[k]  = r_pend;
    assign o_irq[k]   = r_irq;
  end

  always_comb begin
    w_rdat = '0;
    if (w_presc_hit) w_rdat = {16'h0, r_presc};
    for (int k = 0; k < N_TIMERS; k++) begin
      if (w_ch_space && (w_ch == 3'(k))) begin
        case (w_reg)
          2'd0:    w_rdat = {29'h0, w_ctrl[k]};
          2'd1:    w_rdat = 32'(w_load[k]);
          2'd2:    w_rdat = 32'(w_count[k]);
          default: w_rdat = {31'h0, w_pend[k]};
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !i_wb_we) ? w_rdat : '0;
    end
  end

  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_dat;

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer: reset, periodic, one-shot, byte selects, W1C collision, decode, multi-channel.
module tb_wb_timer;
  localparam int N = 4;

  logic          i_clk    = 1'b0;
  logic          i_arst_n = 1'b0;
  logic          i_wb_cyc = 1'b0;
  logic          i_wb_stb = 1'b0;
  logic          i_wb_we  = 1'b0;
  logic [3:0]    i_wb_sel = 4'h0;
  logic [31:0]   i_wb_adr = 32'h0;
  logic [31:0]   i_wb_dat = 32'h0;
  logic [31:0]   o_wb_dat;
  logic          o_wb_ack;
  logic [N-1:0]  o_irq;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int last_req;
  int last_n;

  wb_timer #(.N_TIMERS(N), .CNT_W(32)) dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_stb (i_wb_stb),
    .i_wb_we  (i_wb_we),
    .i_wb_sel (i_wb_sel),
    .i_wb_adr (i_wb_adr),
    .i_wb_dat (i_wb_dat),
    .o_wb_dat (o_wb_dat),
    .o_wb_ack (o_wb_ack),
    .o_irq    (o_irq)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  // last_req is the request edge number, last_n the edges waited for ack.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat);
    int n;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr;  i_wb_dat = dat;  i_wb_sel = sel;
    n = 0; rdat = '0; last_req = -1;
    while (n < 8) begin
      @(posedge i_clk); #1; n++;
      if (o_wb_ack) begin
        rdat = o_wb_dat; last_req = cyc;
        break;
      end
    end
    last_n = n;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    if (last_req < 0) chk("ack_timeout", 32'(n), 32'(1));
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] d;
    xfer(1'b1, adr, dat, sel, d);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    xfer(1'b0, adr, 32'h0, 4'hF, d);
  endtask

  function automatic int cnt_model(int ld, int en_edge, int n);
    return ld - ((n - en_edge) % (ld + 1));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int w, r, c, rise, exp_rise, p, e, x_next;
    int en_edge [N];
    int ld [N];
    logic flag;
    logic [N-1:0] ev;

    // ---------------- reset ----------------
    repeat (2) @(negedge i_clk);
    chk("rst_ack", 32'(o_wb_ack), 0);
    chk("rst_dat", o_wb_dat, 0);
    chk("rst_irq", 32'(o_irq), 0);
    i_arst_n = 1'b1;
    @(negedge i_clk);
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h7);
    repeat (8) @(negedge i_clk);
    chk("pre_irq", 32'(o_irq[0]), 1);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h04; i_wb_sel = 4'hF;
    @(posedge i_clk); #1;
    chk("mid_ack", 32'(o_wb_ack), 1);
    chk("mid_dat", o_wb_dat, 32'd3);
    #2 i_arst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(o_wb_ack), 0);
    chk("arst_dat", o_wb_dat, 0);
    chk("arst_irq", 32'(o_irq), 0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(negedge i_clk);
    i_arst_n = 1'b1;
    flag = 1'b0;
    repeat (3) begin
      @(posedge i_clk); #1;
      if (o_wb_ack) flag = 1'b1;
    end
    chk("rst_no_ack", 32'(flag), 0);
    foreach (ld[k]) begin
      ld[k] = 0;
      en_edge[k] = 0;
    end
    @(negedge i_clk);
    rd(32'h00, d); chk("rst_ctrl0", d, 0);  chk("rst_lat_ctrl", 32'(last_n), 1);
    @(negedge i_clk);
    rd(32'h04, d); chk("rst_load0", d, 0);  chk("rst_lat_load", 32'(last_n), 1);
    @(negedge i_clk);
    rd(32'h08, d); chk("rst_count0", d, 0); chk("rst_lat_count", 32'(last_n), 1);
    @(negedge i_clk);
    rd(32'h80, d); chk("rst_presc", d, 0);  chk("rst_lat_presc", 32'(last_n), 1);

    // ---------------- periodic, period 5 ----------------
    wr(32'h04, 32'd4);
    wr(32'h00, 32'h7);
    w = last_req;
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (o_irq[0]) begin rise = cyc; break; end
    end
    chk("per_irq_rise", 32'(rise - w), 32'd6);
    @(negedge i_clk);
    rd(32'h08, d); r = last_req;
    chk("per_count", d, 32'(cnt_model(4, w, r - 1)));
    rd(32'h0C, d); chk("per_pend", d, 32'd1);
    wr(32'h0C, 32'h1);
    c = last_req;
    @(posedge i_clk); #1;
    chk("per_irq_clr", 32'(o_irq[0]), ((c - w) % 5 == 0) ? 32'd1 : 32'd0);
    x_next = w + 5 * ((c - w) / 5 + 1);
    exp_rise = ((c - w) % 5 == 0) ? c + 2 : x_next + 1;
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      if (o_irq[0]) begin rise = cyc; break; end
    end
    chk("per_irq_again", 32'(rise), 32'(exp_rise));
    @(negedge i_clk);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);

    // ---------------- one-shot, PRESC=2 ----------------
    wr(32'h14, 32'd3);
    wr(32'h80, 32'd2);
    p = last_req;
    repeat (2) @(negedge i_clk);
    wr(32'h10, 32'h5);
    e = last_req;
    chk("os_align", 32'(e - p), 32'd3);
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_irq[1]) begin rise = cyc; break; end
    end
    chk("os_irq_rise", 32'(rise - e), 32'd13);
    @(negedge i_clk);
    rd(32'h10, d); chk("os_ctrl1", d, 32'h4);
    rd(32'h18, d); chk("os_count1", d, 32'h0);
    rd(32'h1C, d); chk("os_pend1", d, 32'h1);
    wr(32'h1C, 32'h1);
    repeat (20) @(negedge i_clk);
    rd(32'h1C, d); chk("os_no_repend", d, 32'h0);
    chk("os_irq_low", 32'(o_irq[1]), 0);

    // ---------------- byte selects ----------------
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h1);
    repeat (10) @(negedge i_clk);
    rd(32'h00, d); chk("bs_en_cleared", d, 32'h0);
    wr(32'h0C, 32'h1);
    wr(32'h04, 32'h11223344);
    wr(32'h04, 32'hAABBCCDD, 4'b0010);
    rd(32'h04, d); chk("bs_load0", d, 32'h1122CC44);
    rd(32'h08, d); chk("bs_count0", d, 32'h0);

    // ---------------- W1C vs expiry on every cycle ----------------
    wr(32'h80, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h7);
    repeat (4) @(negedge i_clk);
    chk("coll_irq_up", 32'(o_irq[0]), 1);
    flag = 1'b0;
    fork
      wr(32'h0C, 32'h1);
      begin
        repeat (6) begin
          @(posedge i_clk); #1;
          if (!o_irq[0]) flag = 1'b1;
        end
      end
    join
    chk("coll_no_drop", 32'(flag), 0);
    @(negedge i_clk);
    rd(32'h0C, d); chk("coll_pend", d, 32'h1);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);

    // ---------------- unmapped offsets ----------------
    rd(32'h50, d); chk("um_rd50", d, 32'h0);
    rd(32'hFC, d); chk("um_rdFC", d, 32'h0);
    wr(32'h50, 32'hFFFFFFFF);
    wr(32'hFC, 32'hFFFFFFFF);
    rd(32'h50, d); chk("um_rd50_after", d, 32'h0);
    rd(32'hFC, d); chk("um_rdFC_after", d, 32'h0);
    rd(32'h80, d); chk("um_presc", d, 32'h0);
    rd(32'h10, d); chk("um_ctrl1", d, 32'h4);
    rd(32'h14, d); chk("um_load1", d, 32'h3);

    // ---------------- four channels, periods 2/3/5/7 ----------------
    ld[0] = 1; ld[1] = 2; ld[2] = 4; ld[3] = 6;
    for (int k = 0; k < N; k++) begin
      wr(32'(16 * k + 4), 32'(ld[k]));
      wr(32'(16 * k + 12), 32'h1);
    end
    for (int k = N - 1; k >= 0; k--) begin
      wr(32'(16 * k), 32'h7);
      en_edge[k] = last_req;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      for (int k = 0; k < N; k++) ev[k] = (cyc >= en_edge[k] + ld[k] + 2);
      chk("mc_irq_vec", 32'(o_irq), 32'(ev));
    end
    @(negedge i_clk);
    for (int k = 0; k < N; k++) begin
      rd(32'(16 * k + 8), d);
      chk("mc_count", d, 32'(cnt_model(ld[k], en_edge[k], last_req - 1)));
    end
    wr(32'h2C, 32'h1);
    c = last_req;
    @(posedge i_clk); #1;
    ev = '1;
    ev[2] = ((c - en_edge[2]) % 5 == 0);
    chk("mc_irq_clr2", 32'(o_irq), 32'(ev));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
